pulse_wave_gen: RTL and testbench

- Digital trapezoid/rectangular stimulus sequencer.
- Sits directly upstream of the pulse and rect current/voltage sources (Ipulse/Irect semantics): it produces the per-sample level codes that a DAC-modelled source consumes.
- Generates delay → rise → high → fall → low phases with linear ramps, one-shot or periodic.
- Streams samples over a valid/ready handshake.

---
 rtl/pulse_wave_gen_pkg.sv | 39 +++
 rtl/pulse_wave_ramp.sv | 43 ++++
 rtl/pulse_wave_gen.sv | 258 +++++++++++++++++++++++++
 tb/tb_pulse_wave_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_wave_gen_pkg.sv
// Shared types and width constants for the pulse_wave_gen sequencer.
// Contents: phase/state encoding, default widths, and helpers that derive
// the ramp multiplier widths (signed difference, k+1 operand, product).
package pulse_wave_gen_pkg;

    localparam int unsigned PWG_DW = 12;  // sample/level code width
    localparam int unsigned PWG_CW = 16;  // delay/high/low duration width
    localparam int unsigned PWG_RW = 4;   // ramp log2 field width

    // Phase encoding; also driven out on the phase port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_RISE  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_FALL  = 3'd4,
        ST_LOW   = 3'd5
    } pwg_state_e;

    // k+1 reaches 2^(2^rw - 1), which needs 2^rw bits.
    function automatic int unsigned pwg_k_w(input int unsigned rw);
        return 32'd1 << rw;
    endfunction

    // Signed difference of two unsigned dw-bit codes.
    function automatic int unsigned pwg_diff_w(input int unsigned dw);
        return dw + 32'd1;
    endfunction

    // Signed product of the difference and the (zero-extended) k+1 term.
    function automatic int unsigned pwg_prod_w(input int unsigned dw, input int unsigned rw);
        return pwg_diff_w(dw) + pwg_k_w(rw) + 32'd1;
    endfunction

    localparam int unsigned PWG_KW     = pwg_k_w(PWG_RW);
    localparam int unsigned PWG_DIFF_W = pwg_diff_w(PWG_DW);
    localparam int unsigned PWG_PROD_W = pwg_prod_w(PWG_DW, PWG_RW);

endpackage

// File: rtl/pulse_wave_ramp.sv
// Linear ramp interpolator (combinational).
// code_c = from_code + floor((to_code - from_code) * kp1 / 2^log2)
// Ports:
//   from_code  in  DW  ramp start level
//   to_code    in  DW  ramp end level
//   kp1        in  KW  1-based beat index within the ramp
//   log2       in  RW  ramp length exponent
//   code_c     out DW  interpolated code
module pulse_wave_ramp
    import pulse_wave_gen_pkg::*;
#(
    parameter int unsigned DW = PWG_DW,
    parameter int unsigned RW = PWG_RW,
    localparam int unsigned KW = pwg_k_w(RW)
) (
    input  logic [DW-1:0] from_code,
    input  logic [DW-1:0] to_code,
    input  logic [KW-1:0] kp1,
    input  logic [RW-1:0] log2,
    output logic [DW-1:0] code_c
);

    localparam int unsigned DIFF_W = pwg_diff_w(DW);
    localparam int unsigned PROD_W = pwg_prod_w(DW, RW);

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] kp1_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;

    // Arithmetic shift floors toward -inf; the result always lies between
    // from_code and to_code, so truncating back to DW bits is lossless.
    always_comb begin
        diff   = $signed({1'b0, to_code}) - $signed({1'b0, from_code});
        diff_x = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
        kp1_x  = {{(PROD_W-KW){1'b0}}, kp1};
        prod   = diff_x * kp1_x;
        step   = prod >>> log2;
        code_c = DW'($signed({{(PROD_W-DW){1'b0}}, from_code}) + step);
    end

endmodule

// File: rtl/pulse_wave_gen.sv
// Trapezoid/rectangular stimulus sequencer: delay -> rise -> high -> fall -> low,
// linear ramps, one-shot or periodic, one sample per accepted valid/ready beat.
// Optional feature macro: PULSE_WAVE_GEN_BURST_EN (adds burst_len / done).
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start, stop       begin (when idle) / abort pulses
//   one_shot          1 = single period, 0 = periodic
//   iv, pv            low and high levels
//   td, th, tl        delay / high / low beat counts
//   tr_log2, tf_log2  rise / fall length exponents
//   burst_len         periods per burst, 0 = unlimited (macro only)
//   done              completion pulse (macro only)
//   out_data/out_valid/out_ready  sample stream
//   busy, phase       status
module pulse_wave_gen
    import pulse_wave_gen_pkg::*;
#(
    parameter int unsigned DW = PWG_DW,
    parameter int unsigned CW = PWG_CW,
    parameter int unsigned RW = PWG_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          one_shot,
    input  logic [DW-1:0] iv,
    input  logic [DW-1:0] pv,
    input  logic [CW-1:0] td,
    input  logic [CW-1:0] th,
    input  logic [CW-1:0] tl,
    input  logic [RW-1:0] tr_log2,
    input  logic [RW-1:0] tf_log2,
`ifdef PULSE_WAVE_GEN_BURST_EN
    input  logic [15:0]   burst_len,
    output logic          done,
`endif
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [2:0]    phase
);

    localparam int unsigned KW    = pwg_k_w(RW);
    localparam int unsigned CNT_W = (CW > KW) ? CW : KW;

    typedef struct packed {
        logic          one_shot;
        logic [DW-1:0] iv;
        logic [DW-1:0] pv;
        logic [CW-1:0] td;
        logic [CW-1:0] th;
        logic [CW-1:0] tl;
        logic [RW-1:0] tr_log2;
        logic [RW-1:0] tf_log2;
`ifdef PULSE_WAVE_GEN_BURST_EN
        logic [15:0]   burst_len;
`endif
    } cfg_t;

    cfg_t             cfg_q, cfg_d, cfg_in, cfg;
    pwg_state_e       state_q, state_d, nxt_state;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_cnt, cnt_inc, phase_len;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [DW-1:0]    ramp_from, ramp_to, ramp_code, sample;
    logic [RW-1:0]    ramp_log2;
    logic [KW-1:0]    ramp_kp1;
    logic             beat, launch, advance, last, wrap, finish;
`ifdef PULSE_WAVE_GEN_BURST_EN
    logic [15:0]      period_q, period_d;
    logic             done_q, done_d;
`endif

    // Configuration snapshot source; live inputs are only observed in IDLE.
    always_comb begin
        cfg_in          = '0;
        cfg_in.one_shot = one_shot;
        cfg_in.iv       = iv;
        cfg_in.pv       = pv;
        cfg_in.td       = td;
        cfg_in.th       = th;
        cfg_in.tl       = tl;
        cfg_in.tr_log2  = tr_log2;
        cfg_in.tf_log2  = tf_log2;
`ifdef PULSE_WAVE_GEN_BURST_EN
        cfg_in.burst_len = burst_len;
`endif
        cfg = (state_q == ST_IDLE) ? cfg_in : cfg_q;
    end

    // Beat count of the current phase and whether this beat is its last.
    always_comb begin
        phase_len = CNT_W'(1);
        unique case (state_q)
            ST_DELAY: phase_len = CNT_W'(cfg.td);
            ST_RISE:  phase_len = CNT_W'(1) << cfg.tr_log2;
            ST_HIGH:  phase_len = CNT_W'(cfg.th);
            ST_FALL:  phase_len = CNT_W'(1) << cfg.tf_log2;
            ST_LOW:   phase_len = CNT_W'(cfg.tl);
            default:  phase_len = CNT_W'(1);
        endcase
        cnt_inc = cnt_q + CNT_W'(1);
        last    = (cnt_inc == phase_len);
        beat    = out_valid_q & out_ready;
        launch  = (state_q == ST_IDLE) & start & ~stop;
        advance = (state_q != ST_IDLE) & ~stop & beat;
    end

    // Next phase/counter; zero-length phases are skipped on entry.
    always_comb begin
        nxt_state = state_q;
        nxt_cnt   = cnt_q;
        wrap      = 1'b0;
        finish    = 1'b0;
`ifdef PULSE_WAVE_GEN_BURST_EN
        period_d  = period_q;
`endif
        if (launch) begin
            nxt_state = (cfg.td != '0) ? ST_DELAY : ST_RISE;
            nxt_cnt   = '0;
`ifdef PULSE_WAVE_GEN_BURST_EN
            period_d  = '0;
`endif
        end else if (advance) begin
            if (!last) begin
                nxt_cnt = cnt_inc;
            end else begin
                nxt_cnt = '0;
                unique case (state_q)
                    ST_DELAY: nxt_state = ST_RISE;
                    ST_RISE:  nxt_state = (cfg.th != '0) ? ST_HIGH : ST_FALL;
                    ST_HIGH:  nxt_state = ST_FALL;
                    ST_FALL: begin
                        if (cfg.tl != '0) nxt_state = ST_LOW;
                        else              wrap      = 1'b1;
                    end
                    ST_LOW:   wrap = 1'b1;
                    default:  nxt_state = ST_IDLE;
                endcase
                // End of a period: periodic mode restarts at RISE (no delay).
                if (wrap) begin
                    if (cfg.one_shot) begin
                        finish = 1'b1;
                    end
`ifdef PULSE_WAVE_GEN_BURST_EN
                    else if ((cfg.burst_len != '0) &&
                             (period_q + 16'd1 == cfg.burst_len)) begin
                        finish = 1'b1;
                    end else begin
                        period_d = period_q + 16'd1;
                    end
`endif
                    nxt_state = finish ? ST_IDLE : ST_RISE;
                end
            end
        end
    end

    // One shared interpolator: operands are swapped for the falling edge.
    always_comb begin
        ramp_from = (nxt_state == ST_FALL) ? cfg.pv : cfg.iv;
        ramp_to   = (nxt_state == ST_FALL) ? cfg.iv : cfg.pv;
        ramp_log2 = (nxt_state == ST_FALL) ? cfg.tf_log2 : cfg.tr_log2;
        ramp_kp1  = KW'(nxt_cnt) + KW'(1);
    end

    pulse_wave_ramp #(
        .DW (DW),
        .RW (RW)
    ) u_ramp (
        .from_code (ramp_from),
        .to_code   (ramp_to),
        .kp1       (ramp_kp1),
        .log2      (ramp_log2),
        .code_c    (ramp_code)
    );

    // Sample to present for the next beat.
    always_comb begin
        sample = cfg.iv;
        unique case (nxt_state)
            ST_RISE, ST_FALL: sample = ramp_code;
            ST_HIGH:          sample = cfg.pv;
            default:          sample = cfg.iv;
        endcase
    end

    // Register next values; stop in a busy phase overrides any advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        cfg_d       = cfg_q;
`ifdef PULSE_WAVE_GEN_BURST_EN
        done_d      = 1'b0;
`endif
        if (launch) begin
            cfg_d = cfg_in;
        end
        if ((state_q != ST_IDLE) && stop) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_data_d  = cfg_q.iv;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else if (launch || advance) begin
            state_d     = nxt_state;
            cnt_d       = nxt_cnt;
            out_data_d  = sample;
            out_valid_d = (nxt_state != ST_IDLE);
            busy_d      = (nxt_state != ST_IDLE);
`ifdef PULSE_WAVE_GEN_BURST_EN
            done_d      = finish;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_q       <= '0;
`ifdef PULSE_WAVE_GEN_BURST_EN
            period_q    <= '0;
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cfg_q       <= cfg_d;
`ifdef PULSE_WAVE_GEN_BURST_EN
            period_q    <= period_d;
            done_q      <= done_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign phase     = state_q;
`ifdef PULSE_WAVE_GEN_BURST_EN
    assign done      = done_q;
`endif

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed self-checking bench for pulse_wave_gen.
module tb_pulse_wave_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, one_shot;
    logic [11:0] iv, pv;
    logic [15:0] td, th, tl;
    logic [3:0]  tr_log2, tf_log2;
    logic [11:0] out_data;
    logic        out_valid, out_ready, busy;
    logic [2:0]  phase;
`ifdef PULSE_WAVE_GEN_BURST_EN
    logic [15:0] burst_len;
    logic        done;
    int          done_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    int beats[$];
    int exp_q[$];
    int cyc;

    pulse_wave_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .one_shot  (one_shot),
        .iv        (iv),
        .pv        (pv),
        .td        (td),
        .th        (th),
        .tl        (tl),
        .tr_log2   (tr_log2),
        .tf_log2   (tf_log2),
`ifdef PULSE_WAVE_GEN_BURST_EN
        .burst_len (burst_len),
        .done      (done),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic os, input int l_iv, input int l_pv, input int l_td,
                           input int l_th, input int l_tl, input int l_tr, input int l_tf);
        one_shot = os;
        iv = 12'(l_iv);  pv = 12'(l_pv);
        td = 16'(l_td);  th = 16'(l_th);  tl = 16'(l_tl);
        tr_log2 = 4'(l_tr);  tf_log2 = 4'(l_tf);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Collect beats until busy drops; mode 1 drives ready as 1,0,0,1,0,0...
    task automatic run_collect(input int max_cyc, input int mode);
        logic        prev_stall;
        logic [11:0] prev_data;
        beats.delete();
        cyc = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
`ifdef PULSE_WAVE_GEN_BURST_EN
        done_cnt = 0;
`endif
        while (busy && cyc < max_cyc) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            chk("valid_while_busy", out_valid, 1);
            if (prev_stall) chk("stall_hold", out_data, prev_data);
            if (out_valid && out_ready) beats.push_back(int'(out_data));
            prev_stall = ~out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
`ifdef PULSE_WAVE_GEN_BURST_EN
            if (done) done_cnt++;
`endif
            cyc++;
        end
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        out_ready = 1'b1;
    endtask

    task automatic chk_beats(input string tag);
        chk($sformatf("%s_count", tag), beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            chk($sformatf("%s_beat[%0d]", tag, i), beats[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        set_cfg(1'b1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PULSE_WAVE_GEN_BURST_EN
        burst_len = '0;
`endif
        #1;
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // start and stop together in IDLE: stop wins
        set_cfg(1'b1, 100, 900, 2, 3, 1, 2, 1);
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_valid", out_valid, 0);
        chk("ss_phase", phase, 0);

        // one-shot, ready held high
        exp_q = '{100, 100, 300, 500, 700, 900, 900, 900, 900, 500, 100, 100};
        do_start();
        chk("os_first_valid", out_valid, 1);
        chk("os_first_phase", phase, 1);
        run_collect(200, 0);
        chk_beats("os");
        chk("os_cycles", cyc, 12);

        // same waveform under backpressure
        do_start();
        run_collect(400, 1);
        chk_beats("bp");
        chk("bp_cycles", cyc, 34);

        // floor rounding, positive and negative ramps
        set_cfg(1'b1, 0, 5, 0, 0, 0, 1, 1);
        exp_q = '{2, 5, 2, 0};
        do_start();
        chk("flA_phase", phase, 2);
        run_collect(50, 0);
        chk_beats("flA");
        set_cfg(1'b1, 5, 0, 0, 0, 0, 1, 1);
        exp_q = '{2, 0, 2, 5};
        do_start();
        run_collect(50, 0);
        chk_beats("flB");

        // periodic with zero durations; restart attempt ignored; stop after beat 7
        set_cfg(1'b0, 0, 4095, 0, 0, 0, 0, 0);
        do_start();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("per_beat[%0d]", i), out_data, (i % 2 == 0) ? 4095 : 0);
            start = (i == 3);
            pv    = (i == 3) ? 12'd1 : 12'd4095;
            stop  = (i == 6);
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0;
        chk("stop_valid", out_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_phase", phase, 0);
        chk("stop_data", out_data, 0);

        // async reset mid-RISE, then a clean restart
        set_cfg(1'b1, 100, 900, 2, 3, 1, 2, 1);
        do_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_phase", phase, 2);
        chk("pre_rst_data", out_data, 300);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", out_data, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_phase", phase, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        chk("rst_restart_phase", phase, 1);
        chk("rst_restart_data", out_data, 100);
        exp_q = '{100, 100, 300, 500, 700, 900, 900, 900, 900, 500, 100, 100};
        run_collect(200, 0);
        chk_beats("rr");

`ifdef PULSE_WAVE_GEN_BURST_EN
        // burst of three periods
        set_cfg(1'b0, 0, 4095, 0, 1, 1, 0, 0);
        burst_len = 16'd3;
        exp_q = '{4095, 4095, 0, 0, 4095, 4095, 0, 0, 4095, 4095, 0, 0};
        do_start();
        burst_len = 16'd0;
        run_collect(100, 0);
        chk_beats("burst");
        chk("burst_done_now", done, 1);
        chk("burst_done_cnt", done_cnt, 1);
        @(posedge clk); #1;
        chk("burst_done_clr", done, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
